// File: rtl/seq_shifter_if.sv
// Handshake and operand/result bundle for seq_shifter.
// SEQ_SHIFTER_ABORT_EN adds the abort request line.
interface seq_shifter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 6
);
    logic              start;
    logic [2:0]        cmd;
    logic [AMT_W-1:0]  amount;
    logic [WIDTH-1:0]  B;
    logic              Cin;
    logic              ready;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  data;
    logic              C;
`ifdef SEQ_SHIFTER_ABORT_EN
    logic              abort;
`endif

    modport master (
`ifdef SEQ_SHIFTER_ABORT_EN
        output abort,
`endif
        output start, cmd, amount, B, Cin,
        input  ready, busy, done, data, C
    );

    modport slave (
`ifdef SEQ_SHIFTER_ABORT_EN
        input  abort,
`endif
        input  start, cmd, amount, B, Cin,
        output ready, busy, done, data, C
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start/busy/done handshake.
// Optional macro SEQ_SHIFTER_ABORT_EN adds an abort input that cancels an operation in SHIFT.
module seq_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    seq_shifter_if.slave  bus
);
    localparam logic [2:0] CMD_SHL  = 3'd0;
    localparam logic [2:0] CMD_SHR  = 3'd1;
    localparam logic [2:0] CMD_ASR  = 3'd2;
    localparam logic [2:0] CMD_ROL  = 3'd3;
    localparam logic [2:0] CMD_ROR  = 3'd4;
    localparam logic [2:0] CMD_ROLN = 3'd5;
    localparam logic [2:0] CMD_RORN = 3'd6;
    localparam logic [2:0] CMD_RSV  = 3'd7;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [2:0]         op;
    logic [AMT_W-1:0]   count;
    logic [WIDTH-1:0]   shift_data;
    logic               carry;
    logic               ready_r;
    logic               busy_r;
    logic               done_r;
    logic               abort_req;

`ifdef SEQ_SHIFTER_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // One single-bit step on {carry, data}; reserved cmd holds its zeroed value.
    function automatic logic [WIDTH:0] step(input logic [2:0] f_op, input logic c,
                                            input logic [WIDTH-1:0] d);
        logic [WIDTH:0] r;
        r = {c, d};
        case (f_op)
            CMD_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            CMD_SHR:  r = {d[0], 1'b0, d[WIDTH-1:1]};
            CMD_ASR:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            CMD_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], c};
            CMD_ROR:  r = {d[0], c, d[WIDTH-1:1]};
            CMD_ROLN: r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            CMD_RORN: r = {d[0], d[0], d[WIDTH-1:1]};
            default:  r = {c, d};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op         <= 3'd0;
            count      <= '0;
            shift_data <= '0;
            carry      <= 1'b0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op    <= bus.cmd;
                        count <= bus.amount;
                        if (bus.cmd == CMD_RSV) begin
                            shift_data <= '0;
                            carry      <= 1'b0;
                        end else begin
                            shift_data <= bus.B;
                            carry      <= bus.Cin;
                        end
                        ready_r <= 1'b0;
                        if (bus.amount == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state  <= SHIFT;
                            busy_r <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    {carry, shift_data} <= step(op, carry, shift_data);
                    count <= count - AMT_W'(1);
                    // Abort wins over the final step handing off to DONE.
                    if (abort_req) begin
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else if (count == AMT_W'(1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.data  = shift_data;
    assign bus.C     = carry;
endmodule

// File: tb/tb_seq_shifter.sv
// Randomized and directed bench for seq_shifter (WIDTH=8) against a closed-form reference model.
module tb_seq_shifter;
    localparam int unsigned W = 8;
    localparam int unsigned AW = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    seq_shifter_if #(.WIDTH(W), .AMT_W(AW)) bus ();
    seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Closed-form result of `amt` steps, computed from whole-operand arithmetic.
    function automatic void model(input logic [2:0] cmd, input int amt, input logic [7:0] b,
                                  input logic cin, output logic [7:0] d, output logic c);
        longint s;
        int v, r;
        d = b; c = cin;
        if (cmd == 3'd7) begin
            d = 8'h00; c = 1'b0;
        end else if (amt != 0) begin
            case (cmd)
                3'd0: begin
                    d = 8'(longint'(b) << amt);
                    c = (amt <= 8) ? 1'((b >> (8 - amt)) & 8'h01) : 1'b0;
                end
                3'd1: begin
                    d = 8'(longint'(b) >> amt);
                    c = (amt <= 8) ? 1'((b >> (amt - 1)) & 8'h01) : 1'b0;
                end
                3'd2: begin
                    s = longint'(b);
                    if (b[7]) s = s - 256;
                    d = 8'(s >>> amt);
                    c = 1'((s >>> (amt - 1)) & 64'd1);
                end
                3'd3, 3'd4: begin
                    v = int'({cin, b});
                    r = amt % 9;
                    if (cmd == 3'd3) v = ((v << r) | (v >> (9 - r))) & 511;
                    else             v = ((v >> r) | (v << (9 - r))) & 511;
                    d = 8'(v);
                    c = 1'(v >> 8);
                end
                default: begin
                    v = int'(b);
                    r = amt % 8;
                    if (cmd == 3'd5) v = (v << r) | (v >> (8 - r));
                    else             v = (v >> r) | (v << (8 - r));
                    d = 8'(v);
                    c = (cmd == 3'd5) ? d[0] : d[7];
                end
            endcase
        end
    endfunction

    // Issue one op from IDLE; returns result, done latency and busy/not-ready cycle counts.
    task automatic do_op(input logic [2:0] cmd, input int amt, input logic [7:0] b,
                         input logic cin, output logic [7:0] d, output logic c,
                         output int lat, output int busy_n, output int nready_n);
        bus.start = 1'b1; bus.cmd = cmd; bus.amount = 6'(amt); bus.B = b; bus.Cin = cin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0; busy_n = 0; nready_n = 0;
        if (bus.busy === 1'b1) busy_n++;
        if (bus.ready === 1'b0) nready_n++;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy === 1'b1) busy_n++;
            if (bus.ready === 1'b0) nready_n++;
        end
        d = bus.data; c = bus.C;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.cmd = 3'd0; bus.amount = '0; bus.B = '0; bus.Cin = 1'b0;
`ifdef SEQ_SHIFTER_ABORT_EN
        bus.abort = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.data, bus.C} !== {3'b100, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got r/b/d=%b%b%b data=%h C=%b, want 100 00 0",
                     bus.ready, bus.busy, bus.done, bus.data, bus.C);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got r/b/d=%b%b%b, want 100", bus.ready, bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        logic [7:0] d; logic c; int lat, bn, nr;
        do_op(3'd0, 1, 8'h81, 1'b0, d, c, lat, bn, nr);
        checks++;
        if (d !== 8'h02 || c !== 1'b1 || lat != 1 || bn != 1) begin
            errors++;
            $display("FAIL shl_0x81: got data=%h C=%b lat=%0d busy=%0d, want 02 1 1 1", d, c, lat, bn);
        end
        do_op(3'd2, 3, 8'h90, 1'b0, d, c, lat, bn, nr);
        checks++;
        if (d !== 8'hF2 || c !== 1'b0 || lat != 3 || nr != 4) begin
            errors++;
            $display("FAIL asr_0x90: got data=%h C=%b lat=%0d notready=%0d, want F2 0 3 4", d, c, lat, nr);
        end
        do_op(3'd3, 9, 8'h80, 1'b0, d, c, lat, bn, nr);
        checks++;
        if (d !== 8'h80 || c !== 1'b0 || lat != 9) begin
            errors++;
            $display("FAIL rol_full_turn: got data=%h C=%b lat=%0d, want 80 0 9", d, c, lat);
        end
        do_op(3'd4, 1, 8'h01, 1'b1, d, c, lat, bn, nr);
        checks++;
        if (d !== 8'h80 || c !== 1'b1) begin
            errors++;
            $display("FAIL ror_carry: got data=%h C=%b, want 80 1", d, c);
        end
        for (int k = 0; k < 7; k++) begin
            do_op(3'(k), 0, 8'h5A, 1'b1, d, c, lat, bn, nr);
            checks++;
            if (d !== 8'h5A || c !== 1'b1 || lat != 0 || bn != 0) begin
                errors++;
                $display("FAIL amount0_cmd%0d: got data=%h C=%b lat=%0d, want 5A 1 0", k, d, c, lat);
            end
        end
        do_op(3'd1, 12, 8'hFF, 1'b1, d, c, lat, bn, nr);
        checks++;
        if (d !== 8'h00 || c !== 1'b0 || lat != 12) begin
            errors++;
            $display("FAIL shr_over_width: got data=%h C=%b lat=%0d, want 00 0 12", d, c, lat);
        end
        do_op(3'd7, 3, 8'hA5, 1'b1, d, c, lat, bn, nr);
        checks++;
        if (d !== 8'h00 || c !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL reserved_cmd: got data=%h C=%b lat=%0d, want 00 0 3", d, c, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] d, ed, b; logic c, ec, cin; logic [2:0] cmd; int amt, lat, bn, nr;
        for (int i = 0; i < 40; i++) begin
            cmd = 3'($urandom_range(0, 7));
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 12));
            b = 8'($urandom); cin = 1'($urandom);
            model(cmd, amt, b, cin, ed, ec);
            do_op(cmd, amt, b, cin, d, c, lat, bn, nr);
            checks++;
            if (d !== ed || c !== ec) begin
                errors++;
                $display("FAIL rand_result cmd=%0d amt=%0d B=%h Cin=%b: got %h/%b want %h/%b",
                         cmd, amt, b, cin, d, c, ed, ec);
            end
            checks++;
            if (lat != amt || bn != amt || nr != amt + 1) begin
                errors++;
                $display("FAIL rand_timing amt=%0d: got lat=%0d busy=%0d notready=%0d, want %0d %0d %0d",
                         amt, lat, bn, nr, amt, amt, amt + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, ed; logic c, ec; int lat, bn, nr;
        for (int i = 0; i < 4; i++) begin
            model(3'd5, i + 2, 8'hC3, 1'b0, ed, ec);
            do_op(3'd5, i + 2, 8'hC3, 1'b0, d, c, lat, bn, nr);
            checks++;
            if (d !== ed || c !== ec || bus.ready !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %h/%b ready=%b want %h/%b 1", i, d, c, bus.ready, ed, ec);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] ed; logic ec; int lat;
        model(3'd0, 4, 8'h81, 1'b0, ed, ec);
        bus.start = 1'b1; bus.cmd = 3'd0; bus.amount = 6'd4; bus.B = 8'h81; bus.Cin = 1'b0;
        @(posedge clk); #1;
        bus.cmd = 3'd1; bus.amount = 6'd2; bus.B = 8'hFF; bus.Cin = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        lat = 2;
        while (bus.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++;
        if (bus.data !== ed || bus.C !== ec || lat != 4) begin
            errors++;
            $display("FAIL start_while_busy: got %h/%b lat=%0d want %h/%b 4", bus.data, bus.C, lat, ed, ec);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        bus.start = 1'b1; bus.cmd = 3'd0; bus.amount = 6'd10; bus.B = 8'hFF; bus.Cin = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: got busy=%b want 1", bus.busy);
        end
        reset = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.start = 1'b0;
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.data, bus.C} !== {3'b100, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_op: got r/b/d=%b%b%b data=%h C=%b, want 100 00 0",
                     bus.ready, bus.busy, bus.done, bus.data, bus.C);
        end
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL no_done_after_reset: got activity=1 want 0");
        end
    endtask

`ifdef SEQ_SHIFTER_ABORT_EN
    task automatic test_abort();
        logic [7:0] d; logic c; int lat, bn, nr; bit saw_done;
        bus.start = 1'b1; bus.cmd = 3'd6; bus.amount = 6'd5; bus.B = 8'h01; bus.Cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.data !== 8'h40) begin
            errors++;
            $display("FAIL abort_shift: got ready=%b done=%b data=%h want 1 0 40", bus.ready, bus.done, bus.data);
        end
        saw_done = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (bus.done === 1'b1) saw_done = 1'b1; end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: got done pulse want none");
        end
        bus.abort = 1'b1;
        do_op(3'd0, 0, 8'h3C, 1'b1, d, c, lat, bn, nr);
        bus.abort = 1'b0;
        checks++;
        if (d !== 8'h3C || c !== 1'b1 || lat != 0) begin
            errors++;
            $display("FAIL abort_idle_done: got %h/%b lat=%0d want 3C/1 0", d, c, lat);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
`ifdef SEQ_SHIFTER_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
